regex_stream_ctx: RTL and testbench
===================================

REGEX_STREAM_CTX -- requirements
Module: regex_stream_ctx

Interface
REQ-001 Parameter NUM_STREAMS, default 64: number of per-stream contexts held.
REQ-002 Parameter SID_W, default 6: stream-id width; NUM_STREAMS SHALL equal 2**SID_W.
REQ-003 Parameter STATE_W, default 11: regex engine state width.
REQ-004 Parameter CNT_W, default 16: per-stream match counter width.
REQ-005 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 load_state  in  1  packet start; load context for stream_id.
REQ-008 stream_id  in  SID_W  stream of the current packet; sampled on load_state.
REQ-009 enable  in  1  matcher enabled for the current stream; sampled on eop.
REQ-010 eop  in  1  end of packet; commit or discard the speculative result.
REQ-011 accept_in  in  1  engine accept pulse.
REQ-012 eng_state  in  STATE_W  engine current state.
REQ-013 state_to_eng  out  STATE_W  state to load into the engine.
REQ-014 state_to_eng_vld  out  1  one-cycle load strobe to the engine.
REQ-015 fired  out  1  speculative match flag for the current packet.
REQ-016 clr_all  in  1  clears all counters and seen bits.
REQ-017 rd_sid  in  SID_W  counter readout address.
REQ-018 rd_count  out  CNT_W  counter for rd_sid, registered, 1-cycle latency.
REQ-019 busy  out  1  high while a packet is open (state ACTIVE).

Function
REQ-020 The block SHALL hold three per-stream arrays: state_mem[STATE_W], count[CNT_W] and a seen bit.
REQ-021 FSM states SHALL be IDLE, LOAD and ACTIVE.
- IDLE -> LOAD on load_state.
- LOAD -> ACTIVE unconditionally after one cycle.
- ACTIVE -> IDLE on eop without load_state.
- ACTIVE -> LOAD on load_state.
REQ-022 On load_state, the block SHALL latch stream_id into cur_sid and clear fired.
REQ-023 In LOAD, the block SHALL drive state_to_eng = state_mem[cur_sid] when seen[cur_sid]=1, and 0 otherwise.
REQ-024 state_to_eng_vld SHALL pulse high for exactly the LOAD cycle, i.e. one cycle after load_state.
REQ-025 In LOAD or ACTIVE, accept_in=1 SHALL set fired; fired SHALL remain set until the next load_state or reset.
REQ-026 eop in ACTIVE with enable=1 SHALL, in that cycle, perform all of the following:
- write state_mem[cur_sid] <= eng_state;
- set seen[cur_sid];
- count[cur_sid] <= count[cur_sid] + (fired OR accept_in).
REQ-027 eop with enable=0 SHALL leave state_mem, seen and count unchanged, and SHALL clear fired.
REQ-028 count SHALL saturate at 2**CNT_W-1 and SHALL never wrap.
REQ-029 accept_in coincident with eop SHALL be counted.
REQ-030 eop and load_state in the same cycle SHALL commit using the old cur_sid first, then latch the new stream_id and enter LOAD.
REQ-031 If the new stream_id equals the committing cur_sid, LOAD SHALL present the just-committed eng_state (write-before-read forwarding).
REQ-032 eop in IDLE or LOAD SHALL be ignored.
REQ-033 load_state in LOAD SHALL restart LOAD with the new stream_id and produce a single strobe for it.
REQ-034 clr_all SHALL zero every count and seen bit on the next edge; state_mem content SHALL be left unchanged but unused until rewritten.
REQ-035 clr_all coincident with an eop commit: the clear SHALL win for counts and seen; the commit's state_mem write SHALL still occur.
REQ-036 rd_count SHALL reflect count[rd_sid] as of the previous edge; no read/write bypass is required.

Reset
REQ-037 While rst_n=0, the block SHALL force:
- FSM to IDLE;
- fired, state_to_eng_vld and busy to 0;
- state_to_eng to 0;
- cur_sid to 0;
- all count and seen entries to 0;
- rd_count to 0.
REQ-038 state_mem SHALL NOT be reset; the seen bits SHALL guard its use.
REQ-039 Reset asserted mid-packet SHALL discard the open packet with no commit.

Verification
REQ-040 Unseen stream: load_state with sid=5 after reset -> next cycle state_to_eng=0 and state_to_eng_vld=1 for exactly one cycle.
REQ-041 Save/restore: sid=5, eng_state=0x123, accept, eop with enable=1 -> count[5]=1; a later load of sid=5 -> state_to_eng=0x123.
REQ-042 Disabled stream: sid=7, accept, eop with enable=0 -> count[7]=0, fired=0 and seen[7]=0.
REQ-043 Saturation: CNT_W=4, 20 matching packets on sid=2 -> rd_count=15.
REQ-044 Back-to-back: eop and load_state in the same cycle, same sid=3, eng_state=0x0AA -> strobe with state_to_eng=0x0AA.
REQ-045 Reset mid-packet after accept -> all counts 0, fired=0, FSM IDLE; next load of that sid -> state_to_eng=0.

Source files
------------

// File: rtl/regex_stream_ctx.sv
// regex_stream_ctx: per-stream regex engine context save/restore.
// Holds engine state, match counters and seen bits for each stream.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   load_state         packet start, restore context for stream_id
//   stream_id          stream of the packet being opened
//   enable             commit enable, sampled with eop
//   eop                end of packet, commit or discard
//   accept_in          engine match pulse
//   eng_state          engine state to save on commit
//   state_to_eng       state restored into the engine (valid in LOAD)
//   state_to_eng_vld   one-cycle restore strobe
//   fired              match seen in the open packet
//   clr_all            clear all counters and seen bits
//   rd_sid, rd_count   counter readout, one-cycle latency
//   busy               packet open (ACTIVE)
module regex_stream_ctx #(
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int STATE_W     = 11,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_state,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic               eop,
  input  logic               accept_in,
  input  logic [STATE_W-1:0] eng_state,
  output logic [STATE_W-1:0] state_to_eng,
  output logic               state_to_eng_vld,
  output logic               fired,
  input  logic               clr_all,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE
  } st_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  st_t st, st_nx;

  logic [SID_W-1:0]   cur_sid;
  logic [STATE_W-1:0] state_mem [NUM_STREAMS];
  logic [CNT_W-1:0]   count [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] seen;

  logic               commit;
  logic               hit;
  logic               fwd;
  logic [STATE_W-1:0] ld_data;
  logic [CNT_W-1:0]   cnt_cur;

  assign commit  = (st == ACTIVE) && eop && enable;
  assign hit     = fired | accept_in;
  assign fwd     = commit && (stream_id == cur_sid);
  assign cnt_cur = count[cur_sid];

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:   if (load_state) st_nx = LOAD;
      LOAD:   st_nx = load_state ? LOAD : ACTIVE;
      ACTIVE: begin
        if (load_state) st_nx = LOAD;
        else if (eop)   st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Restore value: a simultaneous clear makes every stream unseen,
  // and a same-stream commit is forwarded ahead of the array.
  always_comb begin
    ld_data = '0;
    priority case (1'b1)
      clr_all:           ld_data = '0;
      fwd:               ld_data = eng_state;
      seen[stream_id]:   ld_data = state_mem[stream_id];
      default:           ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st               <= IDLE;
      cur_sid          <= '0;
      fired            <= 1'b0;
      state_to_eng_vld <= 1'b0;
      state_to_eng     <= '0;
      busy             <= 1'b0;
      rd_count         <= '0;
      seen             <= '0;
      for (int i = 0; i < NUM_STREAMS; i++)
        count[i] <= '0;
    end else begin
      st               <= st_nx;
      busy             <= (st_nx == ACTIVE);
      state_to_eng_vld <= load_state;
      state_to_eng     <= load_state ? ld_data : '0;
      rd_count         <= count[rd_sid];

      if (load_state)
        cur_sid <= stream_id;

      if (load_state)
        fired <= 1'b0;
      else if ((st == ACTIVE) && eop && !enable)
        fired <= 1'b0;
      else if ((st != IDLE) && accept_in)
        fired <= 1'b1;

      if (clr_all) begin
        seen <= '0;
        for (int i = 0; i < NUM_STREAMS; i++)
          count[i] <= '0;
      end else if (commit) begin
        seen[cur_sid] <= 1'b1;
        if (hit && (cnt_cur != CNT_MAX))
          count[cur_sid] <= cnt_cur + CNT_W'(1);
      end
    end
  end

  // Not reset: seen bits guard every read.
  always_ff @(posedge clk) begin
    if (rst_n && commit)
      state_mem[cur_sid] <= eng_state;
  end

endmodule

// File: tb/tb_regex_stream_ctx.sv
// tb_regex_stream_ctx: directed bench with a restore-value scoreboard.
// Counter width reduced to 4 so saturation is reachable.
module tb_regex_stream_ctx;

  localparam int SID_W   = 6;
  localparam int STATE_W = 11;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_state;
  logic [SID_W-1:0]   stream_id;
  logic               enable;
  logic               eop;
  logic               accept_in;
  logic [STATE_W-1:0] eng_state;
  logic [STATE_W-1:0] state_to_eng;
  logic               state_to_eng_vld;
  logic               fired;
  logic               clr_all;
  logic [SID_W-1:0]   rd_sid;
  logic [CNT_W-1:0]   rd_count;
  logic               busy;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q [$];

  regex_stream_ctx #(
    .NUM_STREAMS (64),
    .SID_W       (SID_W),
    .STATE_W     (STATE_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_state       (load_state),
    .stream_id        (stream_id),
    .enable           (enable),
    .eop              (eop),
    .accept_in        (accept_in),
    .eng_state        (eng_state),
    .state_to_eng     (state_to_eng),
    .state_to_eng_vld (state_to_eng_vld),
    .fired            (fired),
    .clr_all          (clr_all),
    .rd_sid           (rd_sid),
    .rd_count         (rd_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Strobe seen: pop the expected restore value and compare.
  task automatic chk_strobe(string tag);
    logic [31:0] e;
    chk({tag, "_vld"}, 32'(state_to_eng_vld), 32'd1);
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      total--;
      chk({tag, "_ste"}, 32'(state_to_eng), e);
    end
  endtask

  // Open a packet; returns with the FSM in ACTIVE.
  task automatic load(logic [SID_W-1:0] sid, logic [STATE_W-1:0] e);
    stream_id  = sid;
    load_state = 1'b1;
    exp_q.push_back(32'(e));
    step();
    load_state = 1'b0;
    chk_strobe("load");
    chk("load_fired", 32'(fired), 32'd0);
    step();
    chk("load_vld_off", 32'(state_to_eng_vld), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
  endtask

  task automatic accept1();
    accept_in = 1'b1;
    step();
    accept_in = 1'b0;
    chk("acc_fired", 32'(fired), 32'd1);
  endtask

  task automatic pkt_end(logic en, logic [STATE_W-1:0] est, logic acc);
    eop       = 1'b1;
    enable    = en;
    eng_state = est;
    accept_in = acc;
    step();
    eop       = 1'b0;
    enable    = 1'b0;
    accept_in = 1'b0;
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic read_cnt(logic [SID_W-1:0] sid, logic [CNT_W-1:0] e);
    rd_sid = sid;
    step();
    chk("rd_count", 32'(rd_count), 32'(e));
  endtask

  initial begin
    rst_n      = 1'b0;
    load_state = 1'b0;
    stream_id  = '0;
    enable     = 1'b0;
    eop        = 1'b0;
    accept_in  = 1'b0;
    eng_state  = '0;
    clr_all    = 1'b0;
    rd_sid     = '0;
    step();
    step();
    chk("rst_vld", 32'(state_to_eng_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fired", 32'(fired), 32'd0);
    chk("rst_ste", 32'(state_to_eng), 32'd0);
    chk("rst_cnt", 32'(rd_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Unseen stream restores zero; save then restore.
    load(6'd5, 11'h000);
    accept1();
    pkt_end(1'b1, 11'h123, 1'b0);
    chk("fired_hold", 32'(fired), 32'd1);
    read_cnt(6'd5, 4'd1);
    load(6'd5, 11'h123);
    pkt_end(1'b0, 11'h7FF, 1'b0);
    read_cnt(6'd5, 4'd1);

    // Disabled stream: nothing committed, fired dropped.
    load(6'd7, 11'h000);
    accept1();
    pkt_end(1'b0, 11'h055, 1'b0);
    chk("dis_fired", 32'(fired), 32'd0);
    read_cnt(6'd7, 4'd0);
    load(6'd7, 11'h000);
    pkt_end(1'b0, 11'h000, 1'b0);

    // Saturation with accept coincident with eop.
    for (int i = 0; i < 20; i++) begin
      load(6'd2, (i == 0) ? 11'h000 : STATE_W'(i - 1));
      pkt_end(1'b1, STATE_W'(i), 1'b1);
      if (i == 2) read_cnt(6'd2, 4'd3);
    end
    read_cnt(6'd2, 4'd15);

    // Back-to-back eop and load on the same stream.
    load(6'd3, 11'h000);
    eop        = 1'b1;
    enable     = 1'b1;
    eng_state  = 11'h0AA;
    load_state = 1'b1;
    stream_id  = 6'd3;
    exp_q.push_back(32'h0AA);
    step();
    eop        = 1'b0;
    enable     = 1'b0;
    load_state = 1'b0;
    chk_strobe("b2b");
    step();
    pkt_end(1'b0, 11'h000, 1'b0);
    read_cnt(6'd3, 4'd0);

    // eop while idle is ignored.
    eop       = 1'b1;
    enable    = 1'b1;
    accept_in = 1'b1;
    eng_state = 11'h7FF;
    step();
    eop       = 1'b0;
    enable    = 1'b0;
    accept_in = 1'b0;
    read_cnt(6'd5, 4'd1);

    // Reload during LOAD restarts with the new stream.
    stream_id  = 6'd2;
    load_state = 1'b1;
    exp_q.push_back(32'h013);
    step();
    chk_strobe("rl1");
    stream_id = 6'd5;
    exp_q.push_back(32'h123);
    step();
    load_state = 1'b0;
    chk_strobe("rl2");
    step();
    chk("rl_vld_off", 32'(state_to_eng_vld), 32'd0);

    // Clear wins over a coincident commit.
    accept1();
    clr_all = 1'b1;
    pkt_end(1'b1, 11'h321, 1'b1);
    clr_all = 1'b0;
    read_cnt(6'd5, 4'd0);
    read_cnt(6'd2, 4'd0);
    load(6'd5, 11'h000);
    pkt_end(1'b0, 11'h000, 1'b0);

    // Reset in the middle of an open packet.
    load(6'd9, 11'h000);
    accept1();
    pkt_end(1'b1, 11'h044, 1'b0);
    read_cnt(6'd9, 4'd1);
    load(6'd9, 11'h044);
    accept1();
    rst_n     = 1'b0;
    eop       = 1'b1;
    enable    = 1'b1;
    eng_state = 11'h099;
    step();
    eop    = 1'b0;
    enable = 1'b0;
    chk("mid_fired", 32'(fired), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_vld", 32'(state_to_eng_vld), 32'd0);
    rst_n = 1'b1;
    step();
    read_cnt(6'd9, 4'd0);
    load(6'd9, 11'h000);
    pkt_end(1'b0, 11'h000, 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
